// File: rtl/load_miss_buffer.sv
// Load miss buffer: holds loads that wait on an MSHR fill, merges the fill under
// forwarded bytes, then extracts/extends the value and hands it to the CDB.
module load_miss_buffer #(
    parameter int DEPTH       = 8,
    parameter int FILL_PORTS  = 2,
    parameter int MSHR_W      = 3,
    parameter int TAG_W       = 6,
    parameter int BMASK_W     = 4,
    parameter int BLOCK_BYTES = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic [TAG_W-1:0]                  alloc_tag,
    input  logic [MSHR_W-1:0]                 alloc_mshr_idx,
    input  logic [31:0]                       alloc_fwd_data,
    input  logic [3:0]                        alloc_fwd_mask,
    input  logic [$clog2(BLOCK_BYTES)-1:0]    alloc_blk_off,
    input  logic [1:0]                        alloc_size,
    input  logic                              alloc_unsigned,
    input  logic [BMASK_W-1:0]                alloc_bmask,
    input  logic [FILL_PORTS-1:0]             fill_valid,
    input  logic [FILL_PORTS*MSHR_W-1:0]      fill_mshr_idx,
    input  logic [FILL_PORTS*8*BLOCK_BYTES-1:0] fill_data,
    input  logic [BMASK_W-1:0]                b_mm_resolve,
    input  logic                              b_mm_mispred,
    output logic [DEPTH-1:0]                  cdb_req,
    input  logic [DEPTH-1:0]                  cdb_gnt,
    output logic                              result_valid,
    output logic [TAG_W-1:0]                  result_tag,
    output logic [31:0]                       result_data,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy,
    output logic [2*DEPTH-1:0]                dbg_state
);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BLK_W = 8*BLOCK_BYTES;

    typedef enum logic [1:0] {ST_FREE = 2'd0, ST_WAIT = 2'd1, ST_READY = 2'd2} state_t;

    state_t               r_state  [DEPTH];
    logic [TAG_W-1:0]     r_tag    [DEPTH];
    logic [MSHR_W-1:0]    r_mshr   [DEPTH];
    logic [31:0]          r_data   [DEPTH];
    logic [3:0]           r_mask   [DEPTH];
    logic [OFF_W-1:0]     r_off    [DEPTH];
    logic [1:0]           r_size   [DEPTH];
    logic                 r_uns    [DEPTH];
    logic [BMASK_W-1:0]   r_bmask  [DEPTH];
    logic [OCC_W-1:0]     r_occupancy;

    logic [DEPTH-1:0]     w_squash;
    logic [DEPTH-1:0]     w_grant;
    logic [DEPTH-1:0]     w_fill_hit;
    logic [31:0]          w_fill_word   [DEPTH];
    logic [31:0]          w_fill_merged [DEPTH];
    logic [IDX_W-1:0]     w_alloc_idx;
    logic                 w_alloc_we;
    logic                 w_alloc_hit;
    logic [31:0]          w_alloc_word;
    logic [31:0]          w_alloc_data;
    logic                 w_alloc_rdy;
    logic [BMASK_W-1:0]   w_alloc_bmask;
    logic [OCC_W-1:0]     w_n_free;

    function automatic logic [31:0] merge_bytes(input logic [31:0] fwd, input logic [3:0] m,
                                                input logic [31:0] fill);
        logic [31:0] v;
        for (int b = 0; b < 4; b++) v[8*b +: 8] = m[b] ? fwd[8*b +: 8] : fill[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] b,
                                            input logic [1:0] size, input logic uns);
        logic [31:0] s;
        s = d >> {b, 3'b000};
        case (size)
            2'd0:    return {{24{!uns && s[7]}}, s[7:0]};
            2'd1:    return {{16{!uns && s[15]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Scan high to low so the lowest matching port is the one left standing.
    function automatic void find_fill(input logic [MSHR_W-1:0] idx, input logic [OFF_W-1:0] off,
                                      input logic [FILL_PORTS-1:0] fv,
                                      input logic [FILL_PORTS*MSHR_W-1:0] fidx,
                                      input logic [FILL_PORTS*BLK_W-1:0] fdata,
                                      output logic hit, output logic [31:0] word);
        int base;
        hit  = 1'b0;
        word = '0;
        for (int p = FILL_PORTS-1; p >= 0; p--) begin
            if (fv[p] && fidx[p*MSHR_W +: MSHR_W] == idx) begin
                base = p*BLK_W + 32*(int'(off) >> 2);
                hit  = 1'b1;
                word = fdata[base +: 32];
            end
        end
    endfunction

    always_comb begin
        alloc_ready  = 1'b0;
        w_alloc_idx  = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (r_state[i] == ST_FREE) begin
                alloc_ready = 1'b1;
                w_alloc_idx = IDX_W'(i);
            end
        end
        cdb_req      = '0;
        dbg_state    = '0;
        w_squash     = '0;
        w_grant      = '0;
        w_fill_hit   = '0;
        w_n_free     = '0;
        result_valid = 1'b0;
        result_tag   = '0;
        result_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cdb_req[i]          = (r_state[i] == ST_READY);
            dbg_state[2*i +: 2] = r_state[i];
            w_squash[i] = b_mm_mispred && (r_state[i] != ST_FREE) && (|(r_bmask[i] & b_mm_resolve));
            w_grant[i]  = cdb_gnt[i] && (r_state[i] == ST_READY) && !w_squash[i];
            find_fill(r_mshr[i], r_off[i], fill_valid, fill_mshr_idx, fill_data,
                      w_fill_hit[i], w_fill_word[i]);
            w_fill_merged[i] = merge_bytes(r_data[i], r_mask[i], w_fill_word[i]);
            if (w_squash[i] || w_grant[i]) w_n_free = w_n_free + OCC_W'(1);
            if (w_grant[i]) begin
                result_valid = 1'b1;
                result_tag   = r_tag[i];
                result_data  = extract(r_data[i], r_off[i][1:0], r_size[i], r_uns[i]);
            end
        end
        // A same-cycle fill for the allocating load is merged on the way in.
        find_fill(alloc_mshr_idx, alloc_blk_off, fill_valid, fill_mshr_idx, fill_data,
                  w_alloc_hit, w_alloc_word);
        w_alloc_data  = w_alloc_hit ? merge_bytes(alloc_fwd_data, alloc_fwd_mask, w_alloc_word)
                                    : alloc_fwd_data;
        w_alloc_rdy   = w_alloc_hit || (alloc_fwd_mask == 4'hF);
        w_alloc_bmask = b_mm_mispred ? alloc_bmask : (alloc_bmask & ~b_mm_resolve);
        w_alloc_we    = alloc_valid && alloc_ready &&
                        !(b_mm_mispred && (|(alloc_bmask & b_mm_resolve)));
    end

    assign occupancy = r_occupancy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ST_FREE;
                r_tag[i]   <= '0;
                r_mshr[i]  <= '0;
                r_data[i]  <= '0;
                r_mask[i]  <= '0;
                r_off[i]   <= '0;
                r_size[i]  <= '0;
                r_uns[i]   <= 1'b0;
                r_bmask[i] <= '0;
            end
        end else begin
            r_occupancy <= r_occupancy + OCC_W'(w_alloc_we) - w_n_free;
            for (int i = 0; i < DEPTH; i++) begin
                if (r_state[i] != ST_FREE && !b_mm_mispred) r_bmask[i] <= r_bmask[i] & ~b_mm_resolve;
                if (w_squash[i] || w_grant[i]) begin
                    r_state[i] <= ST_FREE;
                end else if (r_state[i] == ST_WAIT && w_fill_hit[i]) begin
                    r_state[i] <= ST_READY;
                    r_data[i]  <= w_fill_merged[i];
                end else if (r_state[i] == ST_FREE && w_alloc_we && w_alloc_idx == IDX_W'(i)) begin
                    r_state[i] <= w_alloc_rdy ? ST_READY : ST_WAIT;
                    r_tag[i]   <= alloc_tag;
                    r_mshr[i]  <= alloc_mshr_idx;
                    r_data[i]  <= w_alloc_data;
                    r_mask[i]  <= alloc_fwd_mask;
                    r_off[i]   <= alloc_blk_off;
                    r_size[i]  <= alloc_size;
                    r_uns[i]   <= alloc_unsigned;
                    r_bmask[i] <= w_alloc_bmask;
                end
            end
        end
    end
endmodule

// File: tb/tb_load_miss_buffer.sv
// Bench for load_miss_buffer: table of single-load vectors through a scoreboard,
// then hand sequences for full buffer, fill bypass/port priority, branches and reset.
module tb_load_miss_buffer;
    logic         clock = 1'b0;
    logic         reset;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [5:0]   alloc_tag;
    logic [2:0]   alloc_mshr_idx;
    logic [31:0]  alloc_fwd_data;
    logic [3:0]   alloc_fwd_mask;
    logic [2:0]   alloc_blk_off;
    logic [1:0]   alloc_size;
    logic         alloc_unsigned;
    logic [3:0]   alloc_bmask;
    logic [1:0]   fill_valid;
    logic [5:0]   fill_mshr_idx;
    logic [127:0] fill_data;
    logic [3:0]   b_mm_resolve;
    logic         b_mm_mispred;
    logic [7:0]   cdb_req;
    logic [7:0]   cdb_gnt;
    logic         result_valid;
    logic [5:0]   result_tag;
    logic [31:0]  result_data;
    logic [3:0]   occupancy;
    logic [15:0]  dbg_state;

    load_miss_buffer dut (
        .clock(clock), .reset(reset), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_tag(alloc_tag), .alloc_mshr_idx(alloc_mshr_idx), .alloc_fwd_data(alloc_fwd_data),
        .alloc_fwd_mask(alloc_fwd_mask), .alloc_blk_off(alloc_blk_off), .alloc_size(alloc_size),
        .alloc_unsigned(alloc_unsigned), .alloc_bmask(alloc_bmask), .fill_valid(fill_valid),
        .fill_mshr_idx(fill_mshr_idx), .fill_data(fill_data), .b_mm_resolve(b_mm_resolve),
        .b_mm_mispred(b_mm_mispred), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt),
        .result_valid(result_valid), .result_tag(result_tag), .result_data(result_data),
        .occupancy(occupancy), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  tag;
        logic [2:0]  idx;
        logic [31:0] fwd;
        logic [3:0]  mask;
        logic [2:0]  off;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[9];
    logic [37:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_tag = 0; alloc_mshr_idx = 0; alloc_fwd_data = 0;
        alloc_fwd_mask = 0; alloc_blk_off = 0; alloc_size = 0; alloc_unsigned = 0;
        alloc_bmask = 0; fill_valid = 0; fill_mshr_idx = 0; fill_data = 0;
        b_mm_resolve = 0; b_mm_mispred = 0; cdb_gnt = 0;
    endtask

    task automatic drive_alloc(input logic [5:0] tag, input logic [2:0] idx, input logic [31:0] fwd,
                               input logic [3:0] mask, input logic [2:0] off, input logic [1:0] size,
                               input logic uns, input logic [3:0] bmask);
        alloc_valid = 1; alloc_tag = tag; alloc_mshr_idx = idx; alloc_fwd_data = fwd;
        alloc_fwd_mask = mask; alloc_blk_off = off; alloc_size = size; alloc_unsigned = uns;
        alloc_bmask = bmask;
    endtask

    task automatic fill_port(input int p, input logic [2:0] idx, input logic [31:0] word,
                             input logic [2:0] off);
        logic [63:0] blk;
        blk = {$urandom, $urandom};
        blk[32*(int'(off) >> 2) +: 32] = word;
        fill_valid[p] = 1'b1;
        fill_mshr_idx[3*p +: 3] = idx;
        fill_data[64*p +: 64] = blk;
    endtask

    // Called at a negedge; grants entry e, checks the result, returns at the next negedge.
    task automatic grant_expect(input int e, input logic [5:0] tag, input logic [31:0] data);
        cdb_gnt = 8'(1 << e);
        #1;
        check("grant_valid", result_valid, 1);
        check("grant_tag", result_tag, tag);
        check("grant_data", result_data, data);
        @(negedge clock);
        cdb_gnt = 0;
    endtask

    initial begin
        vecs[0] = '{6'd5,  3'd2, 32'h0,        4'b0000, 3'd1, 2'd0, 1'b0, 32'h0000_8000, 32'hFFFF_FF80};
        vecs[1] = '{6'd9,  3'd3, 32'h0000_1234, 4'b0011, 3'd0, 2'd2, 1'b0, 32'hAABB_CCDD, 32'hAABB_1234};
        vecs[2] = '{6'd10, 3'd1, 32'h0,        4'b0000, 3'd6, 2'd1, 1'b1, 32'h8765_4321, 32'h0000_8765};
        vecs[3] = '{6'd11, 3'd1, 32'h0,        4'b0000, 3'd6, 2'd1, 1'b0, 32'h8765_4321, 32'hFFFF_8765};
        vecs[4] = '{6'd12, 3'd5, 32'h0,        4'b0000, 3'd7, 2'd0, 1'b1, 32'hF100_0000, 32'h0000_00F1};
        vecs[5] = '{6'd13, 3'd6, 32'h7F00_0000, 4'b1000, 3'd3, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_007F};
        vecs[6] = '{6'd14, 3'd0, 32'h0,        4'b0000, 3'd4, 2'd2, 1'b0, 32'h1234_5678, 32'h1234_5678};
        vecs[7] = '{6'd15, 3'd7, 32'h0000_ABCD, 4'b1111, 3'd0, 2'd1, 1'b0, 32'h0,         32'hFFFF_ABCD};
        vecs[8] = '{6'd16, 3'd4, 32'h0056_0000, 4'b0100, 3'd2, 2'd1, 1'b0, 32'h80FF_0000, 32'hFFFF_8056};

        // Reset state, with a grant held to show nothing leaks out.
        idle();
        reset = 0;
        cdb_gnt = 8'hFF;
        repeat (2) @(negedge clock);
        check("rst_cdb_req", cdb_req, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_tag", result_tag, 0);
        check("rst_result_data", result_data, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        cdb_gnt = 0;
        reset = 1;
        @(negedge clock);

        // Table vectors through the scoreboard.
        for (int v = 0; v < 9; v++) begin
            drive_alloc(vecs[v].tag, vecs[v].idx, vecs[v].fwd, vecs[v].mask, vecs[v].off,
                        vecs[v].size, vecs[v].uns, 4'b0);
            check("vec_alloc_ready", alloc_ready, 1);
            exp_q.push_back({vecs[v].tag, vecs[v].exp});
            @(negedge clock);
            alloc_valid = 0;
            if (vecs[v].mask != 4'hF) begin
                check("vec_wait_state", dbg_state[1:0], 2'd1);
                fill_port(0, vecs[v].idx, vecs[v].word, vecs[v].off);
                fill_port(1, vecs[v].idx ^ 3'd1, ~vecs[v].word, vecs[v].off);
                @(negedge clock);
                fill_valid = 0;
            end
            check("vec_cdb_req", cdb_req, 8'h01);
            cdb_gnt = 8'h01;
            #1;
            check("vec_result_valid", result_valid, 1);
            if (exp_q.size() == 0) begin
                check("vec_sb_empty", 1, 0);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                check("vec_result_tag", result_tag, e[37:32]);
                check("vec_result_data", result_data, e[31:0]);
            end
            @(negedge clock);
            cdb_gnt = 0;
            check("vec_occ_after", occupancy, 0);
        end

        // Full buffer: ninth allocation ignored, freed entry reused the next cycle.
        for (int i = 0; i < 8; i++) begin
            drive_alloc(6'(20 + i), 3'd0, 32'(32'h1000 + i), 4'hF, 3'd0, 2'd2, 1'b0, 4'b0);
            @(negedge clock);
        end
        drive_alloc(6'd40, 3'd0, 32'h4040, 4'hF, 3'd0, 2'd2, 1'b0, 4'b0);
        check("full_occ", occupancy, 8);
        check("full_alloc_ready", alloc_ready, 0);
        check("full_cdb_req", cdb_req, 8'hFF);
        @(negedge clock);
        alloc_valid = 0;
        check("full_occ_ignored", occupancy, 8);
        grant_expect(3, 6'd23, 32'h1003);
        check("full_freed_ready", alloc_ready, 1);
        check("full_freed_req", cdb_req, 8'hF7);
        check("full_freed_occ", occupancy, 7);
        drive_alloc(6'd41, 3'd0, 32'h4141, 4'hF, 3'd0, 2'd2, 1'b0, 4'b0);
        @(negedge clock);
        alloc_valid = 0;
        check("full_refill_req", cdb_req, 8'hFF);
        grant_expect(3, 6'd41, 32'h4141);
        for (int i = 0; i < 8; i++) if (i != 3) grant_expect(i, 6'(20 + i), 32'(32'h1000 + i));
        check("full_drained_occ", occupancy, 0);

        // Alloc/fill bypass with both ports on the same MSHR; port 0 must win.
        drive_alloc(6'd30, 3'd4, 32'h0, 4'h0, 3'd0, 2'd2, 1'b0, 4'b0);
        fill_port(0, 3'd4, 32'h1111_2222, 3'd0);
        fill_port(1, 3'd4, 32'h3333_4444, 3'd0);
        @(negedge clock);
        alloc_valid = 0;
        fill_valid = 0;
        check("bypass_req", cdb_req, 8'h01);
        grant_expect(0, 6'd30, 32'h1111_2222);
        drive_alloc(6'd31, 3'd4, 32'h0, 4'h0, 3'd0, 2'd2, 1'b0, 4'b0);
        @(negedge clock);
        alloc_valid = 0;
        fill_port(0, 3'd4, 32'hAAAA_0001, 3'd0);
        fill_port(1, 3'd4, 32'hBBBB_0002, 3'd0);
        @(negedge clock);
        fill_valid = 0;
        grant_expect(0, 6'd31, 32'hAAAA_0001);
        // Two WAIT entries on one MSHR, filled from port 1 in the same cycle.
        drive_alloc(6'd32, 3'd6, 32'h0, 4'h0, 3'd0, 2'd2, 1'b0, 4'b0);
        @(negedge clock);
        drive_alloc(6'd33, 3'd6, 32'h0, 4'h0, 3'd4, 2'd2, 1'b0, 4'b0);
        @(negedge clock);
        alloc_valid = 0;
        check("shared_wait_req", cdb_req, 8'h00);
        fill_port(0, 3'd5, 32'hDEAD_BEEF, 3'd0);
        fill_valid[1] = 1'b1;
        fill_mshr_idx[5:3] = 3'd6;
        fill_data[127:64] = 64'h6666_7777_5555_4444;
        @(negedge clock);
        fill_valid = 0;
        check("shared_fill_req", cdb_req, 8'h03);
        grant_expect(0, 6'd32, 32'h5555_4444);
        grant_expect(1, 6'd33, 32'h6666_7777);

        // Branch squash beats grant; squashed allocation dropped; correct resolve clears bits.
        drive_alloc(6'd50, 3'd0, 32'h50, 4'hF, 3'd0, 2'd2, 1'b0, 4'b0010);
        @(negedge clock);
        drive_alloc(6'd51, 3'd7, 32'h0, 4'h0, 3'd0, 2'd2, 1'b0, 4'b0100);
        @(negedge clock);
        drive_alloc(6'd52, 3'd0, 32'h52, 4'hF, 3'd0, 2'd2, 1'b0, 4'b0010);
        b_mm_resolve = 4'b0010;
        b_mm_mispred = 1;
        cdb_gnt = 8'h01;
        #1;
        check("squash_result_valid", result_valid, 0);
        check("squash_result_data", result_data, 0);
        @(negedge clock);
        idle();
        check("squash_e0_free", dbg_state[1:0], 2'd0);
        check("squash_e1_wait", dbg_state[3:2], 2'd1);
        check("squash_e2_free", dbg_state[5:4], 2'd0);
        check("squash_occ", occupancy, 1);
        drive_alloc(6'd53, 3'd0, 32'h53, 4'hF, 3'd0, 2'd2, 1'b0, 4'b1100);
        b_mm_resolve = 4'b0100;
        @(negedge clock);
        idle();
        check("resolve_occ", occupancy, 2);
        b_mm_resolve = 4'b0100;
        b_mm_mispred = 1;
        @(negedge clock);
        idle();
        check("cleared_occ", occupancy, 2);
        check("cleared_e0_ready", dbg_state[1:0], 2'd2);
        check("cleared_e1_wait", dbg_state[3:2], 2'd1);
        b_mm_resolve = 4'b1000;
        b_mm_mispred = 1;
        @(negedge clock);
        idle();
        check("late_squash_occ", occupancy, 1);
        check("late_squash_e0", dbg_state[1:0], 2'd0);
        fill_port(0, 3'd7, 32'h5151_5151, 3'd0);
        @(negedge clock);
        fill_valid = 0;
        grant_expect(1, 6'd51, 32'h5151_5151);
        check("branch_drained_occ", occupancy, 0);

        // Reset mid-WAIT with a grant pending.
        drive_alloc(6'd60, 3'd1, 32'h0, 4'h0, 3'd0, 2'd2, 1'b0, 4'b0);
        @(negedge clock);
        drive_alloc(6'd61, 3'd0, 32'h61, 4'hF, 3'd0, 2'd2, 1'b0, 4'b0);
        @(negedge clock);
        alloc_valid = 0;
        cdb_gnt = 8'h02;
        #1;
        check("pre_reset_valid", result_valid, 1);
        check("pre_reset_occ", occupancy, 2);
        reset = 0;
        #1;
        check("async_rst_valid", result_valid, 0);
        check("async_rst_tag", result_tag, 0);
        check("async_rst_data", result_data, 0);
        check("async_rst_req", cdb_req, 0);
        check("async_rst_occ", occupancy, 0);
        check("async_rst_ready", alloc_ready, 1);
        @(negedge clock);
        cdb_gnt = 0;
        reset = 1;
        @(negedge clock);
        check("sb_empty_at_end", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
